addressdecode_datapath_seq: RTL and testbench
=============================================

Name: addressdecode_datapath_seq

Overview:
Clocked, multi-window successor to the combinational Dock data-path control. It sequences the data transceivers and the 0xFF filler driver across I/O cycles, and selects one of N_WIN decode windows by priority. It inserts bus-turnaround dead time on direction changes and stalls the CPU until the target tile is ready. If a mapped tile never responds, a timeout falls back to the filler. It sits between the window decoder (win_hit) and the Dock transceiver/filler enables.

Parameters:
N_WIN, 4, number of decode windows (1..16)
TURN_CYC, 1, dead cycles with all drivers off when direction differs from the previous I/O cycle (0 = none)
TIMEOUT_CYC, 255, max cycles waiting for tile_rdy in a mapped cycle (0 = timeout disabled)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
iorq_n  in  1  CPU I/O request, active-low, synchronous to clk
is_read  in  1  CPU read strobe
is_write  in  1  CPU write strobe
win_hit  in  N_WIN  per-window address match
win_en  in  N_WIN  per-window enable mask
tile_rdy  in  1  selected tile ready
err_clr  in  1  clears timeout_err
data_oe_n  out  1  transceiver enable, active-low
data_dir  out  1  transceiver direction, 1 = tile->CPU (read)
ff_oe_n  out  1  0xFF filler enable, active-low
io_r_w_  out  1  qualified R/W_ to tiles, 1 = read/idle
cpu_wait  out  1  CPU wait request
win_sel  out  $clog2(N_WIN) (min 1)  latched selected window index
timeout_err  out  1  sticky mapped-cycle timeout flag

Behaviour:
- Reset values: data_oe_n=1, ff_oe_n=1, data_dir=1, io_r_w_=1, cpu_wait=0, win_sel=0, timeout_err=0, last_dir=1, state=IDLE.
- All outputs are registered.
- start = ~iorq_n & (is_read ^ is_write). If both strobes are set, or neither is set, with iorq_n low: stay IDLE with outputs idle.
- hit = win_hit & win_en. valid = |hit. win_sel = lowest set index, latched at start; it holds until the next start.
- The direction (is_read) is latched at start. Strobe changes while iorq_n stays low are ignored until iorq_n goes high.
- FSM states: IDLE, TURN, MAPPED, UNMAPPED, TMO, DONE.
- IDLE, on start:
  - If the latched direction != last_dir and TURN_CYC>0: go to TURN.
  - Else: go to MAPPED if valid, otherwise UNMAPPED.
  - Update last_dir.
- TURN:
  - data_oe_n=1, ff_oe_n=1, cpu_wait=1.
  - data_dir takes the new direction on entry.
  - Down-counter runs TURN_CYC cycles, then moves to MAPPED or UNMAPPED.
- MAPPED:
  - data_oe_n=0, data_dir=latched dir, io_r_w_=latched dir.
  - cpu_wait=~tile_rdy, with a one-cycle registered lag.
  - On tile_rdy: go to DONE.
  - When the wait counter equals TIMEOUT_CYC (and TIMEOUT_CYC != 0) without tile_rdy: go to TMO.
- TMO:
  - data_oe_n=1, cpu_wait=0.
  - ff_oe_n=0 if read.
  - Set timeout_err.
  - Hold until iorq_n high.
- UNMAPPED:
  - cpu_wait=0, data_oe_n=1.
  - ff_oe_n=0 if read; writes are discarded, no drivers on.
- DONE: data_oe_n=0, cpu_wait=0; hold until iorq_n high.
- Any state with iorq_n sampled high: next cycle is IDLE, all enables deasserted, io_r_w_=1. data_dir holds its last value.
- Latency: enables assert 1 clk after start is sampled (1+TURN_CYC when turning). They release 1 clk after iorq_n rises.
- Invariant: data_oe_n and ff_oe_n are never both 0 in the same cycle.
- The wait counter is $clog2(TIMEOUT_CYC+1) bits, saturating, and cleared at start.
- err_clr and a timeout event in the same cycle: set wins.
- rst mid-cycle: all outputs return to reset values next edge. The cycle in progress is abandoned; the block waits for a fresh start.

Decomposition:
- Package addressdecode_pkg holds:
  - state enum (IDLE, TURN, MAPPED, UNMAPPED, TMO, DONE)
  - DIR_READ=1'b1 and DIR_WRITE=1'b0
  - OE_ON=1'b0 and OE_OFF=1'b1
- Sub-module addressdecode_prio_enc: parametrised lowest-index priority encoder (hit -> index, valid).

Test Plan:
- Mapped read, N_WIN=4, win_hit=4'b0110, win_en=4'hF, tile_rdy high after 3 clks -> win_sel=1, data_dir=1, data_oe_n=0 from start+1, cpu_wait=1 until rdy+1, ff_oe_n stays 1.
- Read then write back-to-back, TURN_CYC=2 -> on the write, 2 cycles with data_oe_n=ff_oe_n=1 and cpu_wait=1; data_dir=0 from TURN entry; then data_oe_n=0.
- Unmapped read (win_hit=4'b0100, win_en=4'b1011) -> ff_oe_n=0, data_oe_n=1, cpu_wait=0; unmapped write -> both enables 1.
- TIMEOUT_CYC=4, mapped read, tile_rdy never asserted -> after 4 wait cycles data_oe_n=1, ff_oe_n=0, cpu_wait=0, timeout_err=1 sticky; err_clr pulse -> 0; err_clr same cycle as a new timeout -> stays 1.
- is_read and is_write both high with iorq_n low -> no enables, cpu_wait=0, state stays IDLE.
- rst asserted during MAPPED -> next edge all outputs at reset values; iorq_n still low does not restart the cycle.

Source files
------------

// File: rtl/addressdecode_pkg.sv
// Shared types and encodings for the Dock I/O cycle sequencer and its
// window priority encoder.
package addressdecode_pkg;

   typedef enum logic [2:0] {
      IDLE,
      TURN,
      MAPPED,
      UNMAPPED,
      TMO,
      DONE
   } state_t;

   localparam logic DIR_READ  = 1'b1;
   localparam logic DIR_WRITE = 1'b0;

   localparam logic OE_ON  = 1'b0;
   localparam logic OE_OFF = 1'b1;

endpackage

// File: rtl/addressdecode_prio_enc.sv
// Lowest-index-wins priority encoder: returns the index of the lowest set
// bit of hit and whether any bit was set.
module addressdecode_prio_enc
   import addressdecode_pkg::*;
#(
   parameter int N     = 4,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     hit,
   output logic [IDX_W-1:0] idx,
   output logic             valid
);

   always_comb begin
      idx   = '0;
      valid = |hit;
      // Scan downward so the lowest set index is the last one written.
      for (int i = N - 1; i >= 0; i--) begin
         if (hit[i]) begin
            idx = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/addressdecode_datapath_seq.sv
// Clocked Dock data-path sequencer: picks a decode window, inserts bus
// turnaround, stalls the CPU until the tile is ready and falls back to the
// 0xFF filler on unmapped or timed-out cycles.
module addressdecode_datapath_seq
   import addressdecode_pkg::*;
#(
   parameter  int N_WIN       = 4,
   parameter  int TURN_CYC    = 1,
   parameter  int TIMEOUT_CYC = 255,
   localparam int WS_W        = (N_WIN > 1) ? $clog2(N_WIN) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             iorq_n,
   input  logic             is_read,
   input  logic             is_write,
   input  logic [N_WIN-1:0] win_hit,
   input  logic [N_WIN-1:0] win_en,
   input  logic             tile_rdy,
   input  logic             err_clr,
   output logic             data_oe_n,
   output logic             data_dir,
   output logic             ff_oe_n,
   output logic             io_r_w_,
   output logic             cpu_wait,
   output logic [WS_W-1:0]  win_sel,
   output logic             timeout_err
);

   localparam int TC_W = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
   localparam int WC_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

   function automatic logic [WC_W-1:0] sat_inc(input logic [WC_W-1:0] v);
      return (&v) ? v : v + WC_W'(1);
   endfunction

   state_t            state, state_nx;
   logic              dir_q, dir_nx;
   logic              valid_q, valid_nx;
   logic              last_dir, last_dir_nx;
   logic              armed, armed_nx;
   logic [TC_W-1:0]   turn_cnt, turn_cnt_nx;
   logic [WC_W-1:0]   wait_cnt, wait_cnt_nx;
   logic [WC_W-1:0]   wait_inc;
   logic [WS_W-1:0]   win_sel_nx;
   logic              tmo_evt;
   logic              start;

   logic              data_oe_n_nx, ff_oe_n_nx, data_dir_nx;
   logic              io_r_w_nx, cpu_wait_nx, timeout_err_nx;

   logic [N_WIN-1:0]  hit;
   logic [WS_W-1:0]   enc_idx;
   logic              enc_valid;

   assign hit = win_hit & win_en;

   addressdecode_prio_enc #(
      .N     (N_WIN),
      .IDX_W (WS_W)
   ) u_prio_enc (
      .hit   (hit),
      .idx   (enc_idx),
      .valid (enc_valid)
   );

   // armed drops once a cycle is accepted and only re-arms after iorq_n has
   // been seen high, so a held-low iorq_n (or one surviving rst) never
   // starts a second cycle.
   assign start    = armed & ~iorq_n & (is_read ^ is_write);
   assign armed_nx = iorq_n ? 1'b1 : (start ? 1'b0 : armed);
   assign wait_inc = sat_inc(wait_cnt);

   always_comb begin
      state_nx    = state;
      dir_nx      = dir_q;
      valid_nx    = valid_q;
      last_dir_nx = last_dir;
      turn_cnt_nx = turn_cnt;
      wait_cnt_nx = wait_cnt;
      win_sel_nx  = win_sel;
      tmo_evt     = 1'b0;

      if (iorq_n && state != IDLE) begin
         state_nx = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  dir_nx      = is_read;
                  valid_nx    = enc_valid;
                  win_sel_nx  = enc_idx;
                  wait_cnt_nx = '0;
                  last_dir_nx = is_read;
                  if (is_read != last_dir && TURN_CYC > 0) begin
                     state_nx    = TURN;
                     turn_cnt_nx = TC_W'(TURN_CYC - 1);
                  end else begin
                     state_nx = enc_valid ? MAPPED : UNMAPPED;
                  end
               end
            end
            TURN: begin
               if (turn_cnt == '0) begin
                  state_nx = valid_q ? MAPPED : UNMAPPED;
               end else begin
                  turn_cnt_nx = turn_cnt - TC_W'(1);
               end
            end
            MAPPED: begin
               if (tile_rdy) begin
                  state_nx = DONE;
               end else begin
                  wait_cnt_nx = wait_inc;
                  if (TIMEOUT_CYC != 0 && wait_inc == WC_W'(TIMEOUT_CYC)) begin
                     state_nx = TMO;
                     tmo_evt  = 1'b1;
                  end
               end
            end
            default: begin
               state_nx = state;
            end
         endcase
      end
   end

   // Outputs are decoded from the next state so they register alongside it.
   always_comb begin
      data_oe_n_nx = OE_OFF;
      ff_oe_n_nx   = OE_OFF;
      io_r_w_nx    = DIR_READ;
      cpu_wait_nx  = 1'b0;
      data_dir_nx  = data_dir;

      case (state_nx)
         TURN: begin
            cpu_wait_nx = 1'b1;
            data_dir_nx = dir_nx;
         end
         MAPPED: begin
            // Remaining in MAPPED means tile_rdy was low, so wait stays up.
            data_oe_n_nx = OE_ON;
            data_dir_nx  = dir_nx;
            io_r_w_nx    = dir_nx;
            cpu_wait_nx  = 1'b1;
         end
         UNMAPPED, TMO: begin
            data_dir_nx = dir_nx;
            ff_oe_n_nx  = (dir_nx == DIR_READ) ? OE_ON : OE_OFF;
         end
         DONE: begin
            data_oe_n_nx = OE_ON;
            data_dir_nx  = dir_nx;
            io_r_w_nx    = dir_nx;
         end
         default: begin
            data_oe_n_nx = OE_OFF;
         end
      endcase
   end

   assign timeout_err_nx = tmo_evt ? 1'b1 : (err_clr ? 1'b0 : timeout_err);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         dir_q       <= DIR_READ;
         valid_q     <= 1'b0;
         last_dir    <= DIR_READ;
         armed       <= 1'b0;
         turn_cnt    <= '0;
         wait_cnt    <= '0;
         win_sel     <= '0;
         data_oe_n   <= OE_OFF;
         ff_oe_n     <= OE_OFF;
         data_dir    <= DIR_READ;
         io_r_w_     <= DIR_READ;
         cpu_wait    <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_nx;
         dir_q       <= dir_nx;
         valid_q     <= valid_nx;
         last_dir    <= last_dir_nx;
         armed       <= armed_nx;
         turn_cnt    <= turn_cnt_nx;
         wait_cnt    <= wait_cnt_nx;
         win_sel     <= win_sel_nx;
         data_oe_n   <= data_oe_n_nx;
         ff_oe_n     <= ff_oe_n_nx;
         data_dir    <= data_dir_nx;
         io_r_w_     <= io_r_w_nx;
         cpu_wait    <= cpu_wait_nx;
         timeout_err <= timeout_err_nx;
      end
   end

endmodule

// File: tb/tb_addressdecode_datapath_seq.sv
// Directed scoreboard bench for addressdecode_datapath_seq: each stimulus
// cycle queues its expected registered outputs; a monitor checks them.
module tb_addressdecode_datapath_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       iorq_n;
   logic       is_read;
   logic       is_write;
   logic [3:0] win_hit;
   logic [3:0] win_en;
   logic       tile_rdy;
   logic       err_clr;
   logic       data_oe_n;
   logic       data_dir;
   logic       ff_oe_n;
   logic       io_r_w_;
   logic       cpu_wait;
   logic [1:0] win_sel;
   logic       timeout_err;

   int n_chk  = 0;
   int n_fail = 0;

   logic [7:0] exp_q[$];
   string      name_q[$];

   always #5 clk = ~clk;

   addressdecode_datapath_seq #(
      .N_WIN       (4),
      .TURN_CYC    (2),
      .TIMEOUT_CYC (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .iorq_n      (iorq_n),
      .is_read     (is_read),
      .is_write    (is_write),
      .win_hit     (win_hit),
      .win_en      (win_en),
      .tile_rdy    (tile_rdy),
      .err_clr     (err_clr),
      .data_oe_n   (data_oe_n),
      .data_dir    (data_dir),
      .ff_oe_n     (ff_oe_n),
      .io_r_w_     (io_r_w_),
      .cpu_wait    (cpu_wait),
      .win_sel     (win_sel),
      .timeout_err (timeout_err)
   );

   // Expected vector layout: {data_oe_n, ff_oe_n, data_dir, io_r_w_, cpu_wait, timeout_err, win_sel}
   function automatic logic [7:0] ex(input logic doe, input logic foe, input logic dir,
                                     input logic rw, input logic wt, input logic terr,
                                     input logic [1:0] ws);
      return {doe, foe, dir, rw, wt, terr, ws};
   endfunction

   task automatic step(input logic r, input logic iq, input logic rd, input logic wr,
                       input logic [3:0] hit, input logic [3:0] en, input logic rdy,
                       input logic clr, input logic [7:0] e, input string nm);
      @(negedge clk);
      rst      = r;
      iorq_n   = iq;
      is_read  = rd;
      is_write = wr;
      win_hit  = hit;
      win_en   = en;
      tile_rdy = rdy;
      err_clr  = clr;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   // Monitor: every clock the DUT presents a fresh registered output set.
   initial begin
      logic [7:0] e;
      logic [7:0] act;
      string      nm;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = {data_oe_n, ff_oe_n, data_dir, io_r_w_, cpu_wait, timeout_err, win_sel};
            n_chk++;
            if (act !== e) begin
               n_fail++;
               $display("FAIL %s: got {oe,ff,dir,rw,wait,err,sel}=%b required %b", nm, act, e);
            end
            n_chk++;
            if (data_oe_n == 1'b0 && ff_oe_n == 1'b0) begin
               n_fail++;
               $display("FAIL %s_excl: data_oe_n=%b ff_oe_n=%b required not both 0",
                        nm, data_oe_n, ff_oe_n);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; iorq_n = 1'b1; is_read = 1'b0; is_write = 1'b0;
      win_hit = 4'h0; win_en = 4'h0; tile_rdy = 1'b0; err_clr = 1'b0;

      // reset state
      step(1,1,0,0,4'h0,4'hF,0,0, ex(1,1,1,1,0,0,2'd0), "rst0");
      step(1,1,0,0,4'h0,4'hF,0,0, ex(1,1,1,1,0,0,2'd0), "rst1");
      step(0,1,0,0,4'h0,4'hF,0,0, ex(1,1,1,1,0,0,2'd0), "idle0");

      // mapped read, tile ready on the third wait cycle
      step(0,0,1,0,4'b0110,4'hF,0,0, ex(0,1,1,1,1,0,2'd1), "mrd_start");
      step(0,0,1,0,4'b0110,4'hF,0,0, ex(0,1,1,1,1,0,2'd1), "mrd_w1");
      step(0,0,1,0,4'b0110,4'hF,0,0, ex(0,1,1,1,1,0,2'd1), "mrd_w2");
      step(0,0,1,0,4'b0110,4'hF,1,0, ex(0,1,1,1,0,0,2'd1), "mrd_done");
      step(0,1,0,0,4'b0000,4'hF,0,0, ex(1,1,1,1,0,0,2'd1), "mrd_end");

      // mapped write after read: two turnaround cycles
      step(0,0,0,1,4'b1000,4'hF,0,0, ex(1,1,0,1,1,0,2'd3), "wr_turn1");
      step(0,0,0,1,4'b1000,4'hF,0,0, ex(1,1,0,1,1,0,2'd3), "wr_turn2");
      step(0,0,0,1,4'b1000,4'hF,0,0, ex(0,1,0,0,1,0,2'd3), "wr_mapped");
      step(0,0,0,1,4'b1000,4'hF,1,0, ex(0,1,0,0,0,0,2'd3), "wr_done");
      step(0,1,0,0,4'b0000,4'hF,0,0, ex(1,1,0,1,0,0,2'd3), "wr_end");

      // unmapped read (hit masked off) then unmapped write
      step(0,0,1,0,4'b0100,4'b1011,0,0, ex(1,1,1,1,1,0,2'd0), "urd_turn1");
      step(0,0,1,0,4'b0100,4'b1011,0,0, ex(1,1,1,1,1,0,2'd0), "urd_turn2");
      step(0,0,1,0,4'b0100,4'b1011,0,0, ex(1,0,1,1,0,0,2'd0), "urd_fill");
      step(0,0,1,0,4'b0100,4'b1011,0,0, ex(1,0,1,1,0,0,2'd0), "urd_hold");
      step(0,1,0,0,4'b0000,4'hF,0,0,    ex(1,1,1,1,0,0,2'd0), "urd_end");
      step(0,0,0,1,4'b0100,4'b1011,0,0, ex(1,1,0,1,1,0,2'd0), "uwr_turn1");
      step(0,0,0,1,4'b0100,4'b1011,0,0, ex(1,1,0,1,1,0,2'd0), "uwr_turn2");
      step(0,0,0,1,4'b0100,4'b1011,0,0, ex(1,1,0,1,0,0,2'd0), "uwr_drop");
      step(0,1,0,0,4'b0000,4'hF,0,0,    ex(1,1,0,1,0,0,2'd0), "uwr_end");

      // mapped read that times out after four wait cycles
      step(0,0,1,0,4'b0001,4'hF,0,0, ex(1,1,1,1,1,0,2'd0), "tmo_turn1");
      step(0,0,1,0,4'b0001,4'hF,0,0, ex(1,1,1,1,1,0,2'd0), "tmo_turn2");
      step(0,0,1,0,4'b0001,4'hF,0,0, ex(0,1,1,1,1,0,2'd0), "tmo_w1");
      step(0,0,1,0,4'b0001,4'hF,0,0, ex(0,1,1,1,1,0,2'd0), "tmo_w2");
      step(0,0,1,0,4'b0001,4'hF,0,0, ex(0,1,1,1,1,0,2'd0), "tmo_w3");
      step(0,0,1,0,4'b0001,4'hF,0,0, ex(0,1,1,1,1,0,2'd0), "tmo_w4");
      step(0,0,1,0,4'b0001,4'hF,0,0, ex(1,0,1,1,0,1,2'd0), "tmo_fire");
      step(0,0,1,0,4'b0001,4'hF,0,0, ex(1,0,1,1,0,1,2'd0), "tmo_hold");
      step(0,1,0,0,4'b0000,4'hF,0,0, ex(1,1,1,1,0,1,2'd0), "tmo_sticky");
      step(0,1,0,0,4'b0000,4'hF,0,1, ex(1,1,1,1,0,0,2'd0), "err_clr");
      step(0,1,0,0,4'b0000,4'hF,0,0, ex(1,1,1,1,0,0,2'd0), "err_stays0");

      // second timeout with err_clr on the same edge: set wins
      step(0,0,1,0,4'b0001,4'hF,0,0, ex(0,1,1,1,1,0,2'd0), "tmo2_w1");
      step(0,0,1,0,4'b0001,4'hF,0,0, ex(0,1,1,1,1,0,2'd0), "tmo2_w2");
      step(0,0,1,0,4'b0001,4'hF,0,0, ex(0,1,1,1,1,0,2'd0), "tmo2_w3");
      step(0,0,1,0,4'b0001,4'hF,0,0, ex(0,1,1,1,1,0,2'd0), "tmo2_w4");
      step(0,0,1,0,4'b0001,4'hF,0,1, ex(1,0,1,1,0,1,2'd0), "tmo2_setwins");
      step(0,0,1,0,4'b0001,4'hF,0,0, ex(1,0,1,1,0,1,2'd0), "tmo2_hold");
      step(0,1,0,0,4'b0000,4'hF,0,0, ex(1,1,1,1,0,1,2'd0), "tmo2_end");
      step(0,1,0,0,4'b0000,4'hF,0,1, ex(1,1,1,1,0,0,2'd0), "err_clr2");

      // both strobes, then neither strobe: stays idle
      step(0,0,1,1,4'b0010,4'hF,0,0, ex(1,1,1,1,0,0,2'd0), "both_a");
      step(0,0,1,1,4'b0010,4'hF,0,0, ex(1,1,1,1,0,0,2'd0), "both_b");
      step(0,1,0,0,4'b0000,4'hF,0,0, ex(1,1,1,1,0,0,2'd0), "both_end");
      step(0,0,0,0,4'b0010,4'hF,0,0, ex(1,1,1,1,0,0,2'd0), "none");
      step(0,1,0,0,4'b0000,4'hF,0,0, ex(1,1,1,1,0,0,2'd0), "none_end");

      // rst during MAPPED; held-low iorq_n must not restart
      step(0,0,1,0,4'b0100,4'hF,0,0, ex(0,1,1,1,1,0,2'd2), "rm_start");
      step(0,0,1,0,4'b0100,4'hF,0,0, ex(0,1,1,1,1,0,2'd2), "rm_w1");
      step(1,0,1,0,4'b0100,4'hF,0,0, ex(1,1,1,1,0,0,2'd0), "rm_reset");
      step(0,0,1,0,4'b0100,4'hF,0,0, ex(1,1,1,1,0,0,2'd0), "rm_norestart1");
      step(0,0,1,0,4'b0100,4'hF,0,0, ex(1,1,1,1,0,0,2'd0), "rm_norestart2");
      step(0,1,0,0,4'b0000,4'hF,0,0, ex(1,1,1,1,0,0,2'd0), "rm_rearm");
      step(0,0,1,0,4'b0100,4'hF,1,0, ex(0,1,1,1,1,0,2'd2), "rm_restart");
      step(0,0,1,0,4'b0100,4'hF,1,0, ex(0,1,1,1,0,0,2'd2), "rm_done");
      step(0,1,0,0,4'b0000,4'hF,0,0, ex(1,1,1,1,0,0,2'd2), "rm_end");

      repeat (3) @(posedge clk);
      #2;
      n_chk++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending required 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
